// File: rtl/pulse_toggle_tx_pkg.sv
// Shared types for the toggle pulse-crossing protocol.
// Used by both the transmit and receive sides.
package pulse_toggle_tx_pkg;

    typedef enum logic {
        IDLE     = 1'b0,
        WAIT_ACK = 1'b1
    } xfer_state_e;

    localparam int SYNC_STAGES_DEF = 2;

endpackage

// File: rtl/pulse_toggle_tx_sync_bit_n.sv
// N-flop single-bit synchroniser with async active-low reset.
// N must be at least 2.
module sync_bit_n
    import pulse_toggle_tx_pkg::*;
#(
    parameter int N = SYNC_STAGES_DEF
) (
    input  logic clk_i,
    input  logic rst_n_i,
    input  logic d_i,
    output logic q_o
);

    logic [N-1:0] sync_q;

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[N-2:0], d_i};
        end
    end

    assign q_o = sync_q[N-1];

endmodule

// File: rtl/pulse_toggle_tx.sv
// Source side of the toggle pulse crossing: queues pulses and
// launches them one at a time, waiting for each returned ack.
module pulse_toggle_tx
    import pulse_toggle_tx_pkg::*;
#(
    parameter int CNT_W       = 4,
    parameter int SYNC_STAGES = SYNC_STAGES_DEF,
    parameter int TIMEOUT     = 0,
    parameter int TO_W        = 16
) (
    input  logic             src_clk,
    input  logic             src_rst_n,
    input  logic             src_pulse,
    input  logic             clr_err,
    input  logic             ack_toggle,
    output logic             req_toggle,
    output logic             busy,
    output logic             done,
    output logic [CNT_W-1:0] pending_cnt,
    output logic             ovf,
    output logic             timeout_err
);

    localparam logic [CNT_W-1:0] CNT_MAX   = '1;
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
    localparam logic [TO_W-1:0]  TO_LIM    = TO_W'(TIMEOUT);
    localparam logic [TO_W-1:0]  TO_LIM_M1 = TO_W'(TIMEOUT - 1);
    localparam logic [TO_W-1:0]  TO_ONE    = TO_W'(1);
    localparam bit               TO_EN     = (TIMEOUT != 0);

    logic ack_s;

    sync_bit_n #(
        .N (SYNC_STAGES)
    ) u_ack_sync (
        .clk_i   (src_clk),
        .rst_n_i (src_rst_n),
        .d_i     (ack_toggle),
        .q_o     (ack_s)
    );

    xfer_state_e      state_q;
    logic             req_q;
    logic             busy_q;
    logic             done_q;
    logic             ovf_q;
    logic             to_err_q;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    logic [TO_W-1:0]  to_cnt_q;
    logic             launch;
    logic             drop;

    assign launch = (state_q == IDLE) && (cnt_q != '0);
    // A launch frees a slot, so a saturated queue still accepts that pulse
    assign drop   = src_pulse && !launch && (cnt_q == CNT_MAX);

    always_comb begin
        cnt_d = cnt_q;
        if (src_pulse && !launch && !drop) begin
            cnt_d = cnt_q + CNT_ONE;
        end else if (launch && !src_pulse) begin
            cnt_d = cnt_q - CNT_ONE;
        end
    end

    always_ff @(posedge src_clk or negedge src_rst_n) begin
        if (!src_rst_n) begin
            cnt_q <= '0;
            ovf_q <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            if (drop) begin
                ovf_q <= 1'b1;
            end else if (clr_err) begin
                ovf_q <= 1'b0;
            end
        end
    end

    always_ff @(posedge src_clk or negedge src_rst_n) begin
        if (!src_rst_n) begin
            state_q  <= IDLE;
            req_q    <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            to_cnt_q <= '0;
            to_err_q <= 1'b0;
        end else begin
            done_q <= 1'b0;
            if (clr_err) begin
                to_err_q <= 1'b0;
            end
            unique case (state_q)
                IDLE: begin
                    if (launch) begin
                        req_q    <= ~req_q;
                        busy_q   <= 1'b1;
                        to_cnt_q <= '0;
                        state_q  <= WAIT_ACK;
                    end
                end
                WAIT_ACK: begin
                    if (ack_s == req_q) begin
                        done_q  <= 1'b1;
                        busy_q  <= 1'b0;
                        state_q <= IDLE;
                    end else if (TO_EN && (to_cnt_q != TO_LIM)) begin
                        to_cnt_q <= to_cnt_q + TO_ONE;
                        if (to_cnt_q == TO_LIM_M1) begin
                            to_err_q <= 1'b1;
                        end
                    end
                end
            endcase
        end
    end

    assign req_toggle  = req_q;
    assign busy        = busy_q;
    assign done        = done_q;
    assign pending_cnt = cnt_q;
    assign ovf         = ovf_q;
    assign timeout_err = to_err_q;

endmodule

// File: tb/tb_pulse_toggle_tx.sv
// Bench for pulse_toggle_tx: directed scenarios plus random traffic,
// checked every cycle against a protocol-level reference model.
module tb_pulse_toggle_tx;

    localparam int CW   = 3;
    localparam int NS   = 2;
    localparam int TO   = 10;
    localparam int TW   = 8;
    localparam int PMAX = (1 << CW) - 1;

    logic          src_clk    = 1'b0;
    logic          src_rst_n  = 1'b0;
    logic          src_pulse  = 1'b0;
    logic          clr_err    = 1'b0;
    logic          ack_toggle = 1'b0;
    logic          req_toggle;
    logic          busy;
    logic          done;
    logic [CW-1:0] pending_cnt;
    logic          ovf;
    logic          timeout_err;

    int tests = 0;
    int fails = 0;

    always #5 src_clk = ~src_clk;

    pulse_toggle_tx #(
        .CNT_W       (CW),
        .SYNC_STAGES (NS),
        .TIMEOUT     (TO),
        .TO_W        (TW)
    ) dut (
        .src_clk     (src_clk),
        .src_rst_n   (src_rst_n),
        .src_pulse   (src_pulse),
        .clr_err     (clr_err),
        .ack_toggle  (ack_toggle),
        .req_toggle  (req_toggle),
        .busy        (busy),
        .done        (done),
        .pending_cnt (pending_cnt),
        .ovf         (ovf),
        .timeout_err (timeout_err)
    );

    // reference model: pending events, in-flight flag, waited cycles
    int    m_pend;
    int    m_waited;
    bit    m_busy;
    bit    m_req;
    bit    m_done;
    bit    m_ovf;
    bit    m_terr;
    bit    m_ackhist[$];

    // far-side echo agent
    int    dly  = 1;
    bit    hold = 1'b0;
    bit    reqh[$];
    string phase = "init";

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    function automatic void model_reset();
        m_pend   = 0;
        m_waited = 0;
        m_busy   = 1'b0;
        m_req    = 1'b0;
        m_done   = 1'b0;
        m_ovf    = 1'b0;
        m_terr   = 1'b0;
        m_ackhist.delete();
        for (int i = 0; i < NS; i++) m_ackhist.push_back(1'b0);
    endfunction

    function automatic void model_edge(input bit p, input bit c, input bit a);
        bit acked_view;
        bit launch;
        bit ovf_set;
        bit to_set;
        acked_view = m_ackhist[NS-1];
        launch     = !m_busy && (m_pend > 0);
        ovf_set    = 1'b0;
        to_set     = 1'b0;
        m_done     = 1'b0;
        if (launch) begin
            m_req    = !m_req;
            m_busy   = 1'b1;
            m_waited = 0;
        end else if (m_busy) begin
            if (acked_view == m_req) begin
                m_done = 1'b1;
                m_busy = 1'b0;
            end else begin
                m_waited++;
                if (m_waited == TO) to_set = 1'b1;
            end
        end
        if (p && !launch) begin
            if (m_pend == PMAX) ovf_set = 1'b1;
            else m_pend++;
        end else if (launch && !p) begin
            m_pend--;
        end
        m_ovf  = ovf_set ? 1'b1 : (c ? 1'b0 : m_ovf);
        m_terr = to_set ? 1'b1 : (c ? 1'b0 : m_terr);
        m_ackhist.push_front(a);
        void'(m_ackhist.pop_back());
    endfunction

    task automatic check_all();
        chk({phase, ".req"},  req_toggle,  m_req);
        chk({phase, ".busy"}, busy,        m_busy);
        chk({phase, ".done"}, done,        m_done);
        chk({phase, ".pend"}, pending_cnt, m_pend);
        chk({phase, ".ovf"},  ovf,         m_ovf);
        chk({phase, ".terr"}, timeout_err, m_terr);
    endtask

    task automatic step(input bit p, input bit c);
        src_pulse = p;
        clr_err   = c;
        if (!hold && reqh.size() >= dly) ack_toggle = reqh[dly-1];
        @(posedge src_clk);
        model_edge(p, c, ack_toggle);
        #1;
        reqh.push_front(req_toggle);
        if (reqh.size() > 16) void'(reqh.pop_back());
        check_all();
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, ".req"},  req_toggle,  0);
        chk({tag, ".busy"}, busy,        0);
        chk({tag, ".done"}, done,        0);
        chk({tag, ".pend"}, pending_cnt, 0);
        chk({tag, ".ovf"},  ovf,         0);
        chk({tag, ".terr"}, timeout_err, 0);
    endtask

    task automatic do_reset(input string tag);
        src_rst_n  = 1'b0;
        src_pulse  = 1'b0;
        clr_err    = 1'b0;
        ack_toggle = 1'b0;
        hold       = 1'b0;
        #1;
        chk_all_zero(tag);
        model_reset();
        reqh.delete();
        @(posedge src_clk);
        #1;
        src_rst_n = 1'b1;
    endtask

    initial begin
        #100000;
        fails++;
        $display("FAIL watchdog observed=timeout expected=finish");
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $fatal(1, "watchdog expired");
    end

    initial begin
        int  edge_no;
        int  busy_n;
        int  peak;
        int  ntog;
        int  ndone;
        int  n;
        bit  prev;
        bit  found;

        model_reset();
        #12;
        do_reset("reset");

        // single event, echo after 5 cycles
        phase = "single";
        dly = 5;
        step(1'b1, 1'b0);
        chk("single.pend_after_pulse", pending_cnt, 1);
        step(1'b0, 1'b0);
        chk("single.req_flip", req_toggle, 1);
        chk("single.busy_rise", busy, 1);
        chk("single.pend_launched", pending_cnt, 0);
        edge_no = 1;
        busy_n  = 1;
        found   = 1'b0;
        for (int i = 0; i < 30 && !found; i++) begin
            step(1'b0, 1'b0);
            edge_no++;
            if (busy) busy_n++;
            if (done) found = 1'b1;
        end
        chk("single.done_edge", edge_no, 8);
        chk("single.busy_cycles", busy_n, 7);
        repeat (3) step(1'b0, 1'b0);
        chk("single.pend_end", pending_cnt, 0);

        // burst of 6, echo after 3
        do_reset("burst_rst");
        phase = "burst";
        dly   = 3;
        peak  = 0;
        ntog  = 0;
        ndone = 0;
        prev  = req_toggle;
        for (int i = 0; i < 60; i++) begin
            step(i < 6, 1'b0);
            if (i == 1) begin
                chk("simul.pend", pending_cnt, 1);
                chk("simul.ovf", ovf, 0);
            end
            if (int'(pending_cnt) > peak) peak = int'(pending_cnt);
            if (req_toggle != prev) ntog++;
            prev = req_toggle;
            if (done) ndone++;
        end
        chk("burst.peak", peak, 5);
        chk("burst.toggles", ntog, 6);
        chk("burst.dones", ndone, 6);
        chk("burst.final_req", req_toggle, 0);

        // overflow with echo held off
        do_reset("ovf_rst");
        phase = "ovf";
        hold  = 1'b1;
        for (int i = 0; i < 9; i++) step(1'b1, 1'b0);
        chk("ovf.sat", pending_cnt, PMAX);
        chk("ovf.flag", ovf, 1);
        step(1'b0, 1'b1);
        chk("ovf.cleared", ovf, 0);
        hold = 1'b0;
        ntog = 1;
        prev = req_toggle;
        for (int i = 0; i < 100; i++) begin
            step(1'b0, 1'b0);
            if (req_toggle != prev) ntog++;
            prev = req_toggle;
        end
        chk("ovf.launches", ntog, PMAX + 1);
        chk("ovf.pend_end", pending_cnt, 0);
        step(1'b0, 1'b1);

        // timeout, then a late echo
        do_reset("to_rst");
        phase = "timeout";
        hold  = 1'b1;
        step(1'b1, 1'b0);
        step(1'b0, 1'b0);
        chk("timeout.busy", busy, 1);
        n = 0;
        for (int i = 0; i < 40 && !timeout_err; i++) begin
            step(1'b0, 1'b0);
            n++;
        end
        chk("timeout.cycles", n, TO);
        repeat (5) step(1'b0, 1'b0);
        chk("timeout.still_busy", busy, 1);
        hold  = 1'b0;
        found = 1'b0;
        for (int i = 0; i < 20 && !found; i++) begin
            step(1'b0, 1'b0);
            if (done) found = 1'b1;
        end
        chk("timeout.late_done", found, 1);
        chk("timeout.sticky", timeout_err, 1);
        step(1'b0, 1'b1);
        chk("timeout.cleared", timeout_err, 0);

        // reset in the middle of a wait
        phase = "midrst";
        hold  = 1'b1;
        repeat (3) step(1'b1, 1'b0);
        chk("midrst.busy", busy, 1);
        chk("midrst.pend", pending_cnt, 2);
        #2;
        do_reset("midrst.async");
        for (int i = 0; i < 10; i++) step(1'b0, 1'b0);
        chk("midrst.no_launch", req_toggle, 0);
        chk("midrst.idle", busy, 0);

        // random traffic
        phase = "rand";
        for (int i = 0; i < 400; i++) begin
            if (i % 25 == 0) begin
                dly  = $urandom_range(1, 6);
                hold = ($urandom_range(0, 9) == 0);
            end
            step($urandom_range(0, 2) == 0, $urandom_range(0, 19) == 0);
        end
        hold = 1'b0;
        dly  = 2;
        for (int i = 0; i < 120; i++) step(1'b0, 1'b0);
        chk("rand.drained", pending_cnt, 0);
        chk("rand.idle", busy, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/pulse_toggle_tx.md
Name: pulse_toggle_tx

Overview:
Source-side initiator of the toggle pulse-crossing protocol, in the src_clk domain. Queues src_pulse events in a counter. Launches them one at a time as transitions on req_toggle. Each launch waits for the far side's returned ack_toggle, resynchronised locally, before the next launch. This makes the crossing lossless: a burst of source pulses is never merged at the destination.

Parameters:
CNT_W, 4, width of pending-event counter; max queued events = 2^CNT_W-1
SYNC_STAGES, 2, flops in the ack_toggle synchroniser (legal >= 2)
TIMEOUT, 0, src_clk cycles in WAIT_ACK before timeout_err sets; 0 disables the timer
TO_W, 16, width of the timeout counter (TIMEOUT < 2^TO_W)

Ports:
src_clk  input  1  block clock
src_rst_n  input  1  asynchronous active-low reset
src_pulse  input  1  one event per high cycle
clr_err  input  1  clears ovf and timeout_err (sticky flags)
ack_toggle  input  1  returned toggle from the destination domain; asynchronous to src_clk
req_toggle  output  1  launch toggle to the destination domain; registered, glitch-free
busy  output  1  high while in WAIT_ACK
done  output  1  one-cycle pulse when an ack completes
pending_cnt  output  CNT_W  events queued but not yet launched
ovf  output  1  sticky: an event was dropped at counter saturation
timeout_err  output  1  sticky: ack not seen within TIMEOUT cycles

Behaviour:
- Clocking and reset: single clock src_clk; reset src_rst_n is asynchronous, active-low.
- Reset values: every output and all internal flops are 0; the FSM is in IDLE. Reset mid-handshake abandons it. Both ends must be reset together; no recovery protocol is defined.
- Synchroniser: ack_toggle passes through SYNC_STAGES flops to give ack_s. ack_toggle is used nowhere else.
- Queue: each src_pulse increments pending_cnt.
  - A launch in the same cycle decrements it.
  - A pulse plus a launch together leave the count unchanged.
- Saturation: at pending_cnt = 2^CNT_W-1, a pulse with no simultaneous launch is dropped and ovf <= 1. A pulse with a simultaneous launch is accepted; no overflow.
- FSM IDLE:
  - If the registered pending_cnt != 0: launch, i.e. req_toggle <= ~req_toggle, decrement, go to WAIT_ACK, busy <= 1.
  - If pending_cnt = 0: stay in IDLE.
- FSM WAIT_ACK:
  - When ack_s == req_toggle: done <= 1 for one cycle, busy <= 0, go to IDLE.
  - Otherwise stay, and increment the timeout counter.
- Back-to-back: the earliest next launch is the cycle after done.
- Timeout: applies when TIMEOUT != 0.
  - When the counter reaches TIMEOUT, timeout_err <= 1 and the FSM stays in WAIT_ACK (no retransmit).
  - The counter clears on entry to WAIT_ACK.
  - It saturates at TIMEOUT.
- clr_err: clears ovf and timeout_err next cycle. A new set event in the same cycle wins over clear.
- Latency, src_pulse seen at edge k with IDLE and pending 0:
  - pending_cnt = 1 after edge k.
  - req_toggle flips, pending_cnt = 0 and busy = 1 after edge k+1.
- Ack latency: ack_toggle changes and is captured at edge m. ack_s matches after edge m+SYNC_STAGES-1. done = 1 and busy = 0 after edge m+SYNC_STAGES.
- Width rule: all counter arithmetic is unsigned, with no wrap. pending_cnt never wraps from max to 0 or from 0 to max.
- req_toggle comes directly from a flop; there is no combinational path to any output.

Decomposition:
- Shared package: FSM state enum (IDLE, WAIT_ACK) and the SYNC_STAGES default constant. The package is reused by the receive side.
- One natural sub-module: sync_bit_n, a parameterised N-flop synchroniser with async active-low reset, instantiated for ack_toggle.

Test Plan:
- Single event: pulse at cycle 0; far-side model echoes req_toggle after 5 cycles -> req_toggle 0->1 at cycle 2, done at cycle 2+5+2, pending_cnt back to 0, busy 1 for exactly the wait.
- Burst: 6 consecutive src_pulse cycles, echo delay 3 -> pending_cnt peaks at 5 (one launched immediately), exactly 6 req_toggle transitions, 6 done pulses, final req_toggle = 0.
- Overflow: CNT_W=2, echo held off, 5 pulses -> one launched, pending_cnt saturates at 3, ovf = 1 after 5th pulse; clr_err -> ovf 0; release echo -> 4 total launches.
- Simultaneous: pulse in the same cycle as a launch with pending_cnt = 1 -> pending_cnt stays 1, no ovf.
- Timeout: TIMEOUT=10, never echo -> timeout_err = 1 exactly 10 cycles after busy rises; late echo later -> done pulses, error stays set until clr_err.
- Reset mid-wait: assert src_rst_n low while busy with pending_cnt = 2 -> all outputs 0 asynchronously; after release no launch without new pulses.
